// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and RAM status types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/diaosi_types_pkg.sv
// diaosi_types_pkg: arbiter state encoding and saturating increment helper.
package diaosi_types_pkg;
  import cpu_types_pkg::*;
  typedef enum logic [1:0] {IDLE, DACC, IFETCH, FAULT} arb_state_t;
  function automatic word_t sat_inc(word_t v, logic en);
    return (en && v != '1) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: saturating fetch/data/stall event counters for mem_arbiter.
module mem_arb_perf
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  logic  dhit,
  input  logic  stall,
  output word_t icount,
  output word_t dcount,
  output word_t scount
);
  word_t icount_q, icount_d, dcount_q, dcount_d, scount_q, scount_d;
  always_comb begin
    icount_d = sat_inc(icount_q, ihit);
    dcount_d = sat_inc(dcount_q, dhit);
    scount_d = sat_inc(scount_q, stall);
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
      scount_q <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
      scount_q <= scount_d;
    end
  end
  assign icount = icount_q;
  assign dcount = dcount_q;
  assign scount = scount_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority, non-preemptive arbiter of I-fetch and data ports onto one RAM.
// Define MEM_ARB_PERF_EN to build the mem_arb_perf counters; otherwise the counter ports read 0.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ihit,
  output logic      dhit,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  output logic      mem_err,
  output word_t     icount,
  output word_t     dcount,
  output word_t     scount
);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);
  arb_state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d, wait_inc;
  logic d_req, access, stall;
  always_comb begin
    d_req    = dREN | dWEN;
    access   = ramstate == ACCESS;
    stall    = (state_q == DACC || state_q == IFETCH) && !access;
    ihit     = state_q == IFETCH && iREN && access;
    dhit     = state_q == DACC && d_req && access;
    iload    = ihit ? ramload : '0;
    dload    = dhit ? ramload : '0;
    ramaddr  = state_q == DACC ? daddr : state_q == IFETCH ? iaddr : '0;
    ramstore = state_q == DACC ? dstore : '0;
    ramWEN   = state_q == DACC && dWEN;
    ramREN   = (state_q == DACC && dREN && !dWEN) || state_q == IFETCH;
    mem_err  = state_q == FAULT;
    wait_inc = wait_q + 1'b1;
    state_d  = state_q;
    // ERROR outranks withdrawal; the timeout trips on the TIMEOUT-th stalled cycle of a grant
    unique case (state_q)
      IDLE:   state_d = d_req ? DACC : iREN ? IFETCH : IDLE;
      DACC:   state_d = ramstate == ERROR ? FAULT : !d_req ? IDLE :
                        access ? (iREN ? IFETCH : IDLE) : wait_inc == TMAX ? FAULT : DACC;
      IFETCH: state_d = ramstate == ERROR ? FAULT : !iREN ? IDLE :
                        access ? (d_req ? DACC : IDLE) : wait_inc == TMAX ? FAULT : IFETCH;
      FAULT:  state_d = FAULT;
    endcase
    wait_d = state_d != state_q ? '0 : stall ? wait_inc : wait_q;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
`ifdef MEM_ARB_PERF_EN
  mem_arb_perf u_perf (
    .CLK   (CLK),
    .nRST  (nRST),
    .ihit  (ihit),
    .dhit  (dhit),
    .stall (stall),
    .icount(icount),
    .dcount(dcount),
    .scount(scount)
  );
`else
  assign icount = '0;
  assign dcount = '0;
  assign scount = '0;
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, max consecutive non-ACCESS cycles tolerated in one grant before fault.
REQ-002 CLK  in  1  clock, all state updates on rising edge.
REQ-003 nRST  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 iREN  in  1  instruction fetch request, held until ihit.
REQ-005 iaddr  in  32  instruction word address.
REQ-006 dREN  in  1  data read request, held until dhit.
REQ-007 dWEN  in  1  data write request, held until dhit.
REQ-008 daddr  in  32  data address.
REQ-009 dstore  in  32  write data.
REQ-010 ramload  in  32  RAM read data.
REQ-011 ramstate  in  ramstate_t  RAM status FREE/BUSY/ACCESS/ERROR.
REQ-012 ihit, dhit  out  1  one-cycle completion pulses.
REQ-013 iload, dload  out  32  read data, valid with the matching hit.
REQ-014 ramREN, ramWEN  out  1  RAM read/write strobes.
REQ-015 ramaddr, ramstore  out  32  RAM address/write data.
REQ-016 mem_err  out  1  sticky fault flag.
REQ-017 icount, dcount, scount  out  32  performance counters (REQ-034).

Function
REQ-018 FSM states SHALL be IDLE, DACC, IFETCH, FAULT.
REQ-019 IDLE: dREN|dWEN -> DACC; else iREN -> IFETCH; else stay; data has priority on simultaneous requests.
REQ-020 IDLE drives ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, no hits.
REQ-021 DACC drives ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-022 IFETCH drives ramaddr=iaddr, ramREN=1, ramWEN=0.
REQ-023 In DACC with ramstate==ACCESS: dhit=1 same cycle, dload=ramload; next state IFETCH if iREN else IDLE.
REQ-024 In IFETCH with ramstate==ACCESS: ihit=1 same cycle, iload=ramload; next state DACC if dREN|dWEN else IDLE.
REQ-025 No preemption: a granted access completes before the other requester is served.
REQ-026 Request withdrawn while granted (DACC with dREN=dWEN=0, IFETCH with iREN=0): return to IDLE next cycle, no hit.
REQ-027 iload/dload SHALL be 0 when the matching hit is 0.
REQ-028 Wait counter SHALL clear on entering DACC/IFETCH and increment each granted cycle without ACCESS; width ceil(log2(TIMEOUT+1)).
REQ-029 ramstate==ERROR, or counter==TIMEOUT without ACCESS, SHALL move to FAULT next cycle.
REQ-030 FAULT: mem_err=1, all RAM strobes 0, no hits; exit only via reset.

Reset
REQ-031 nRST low SHALL immediately force IDLE, wait counter 0, mem_err 0, counters 0.
REQ-032 Reset mid-access SHALL abandon it; no hit is produced for it.
REQ-033 All outputs SHALL be 0 while in reset.

Configuration
REQ-034 Macro MEM_ARB_PERF_EN defined: icount/dcount increment per ihit/dhit, scount per granted cycle without ACCESS, all saturating at 32'hFFFFFFFF.
REQ-035 MEM_ARB_PERF_EN undefined: counter logic absent, icount/dcount/scount tied to 0; ports remain.

Structure
REQ-036 State enum arb_state_t SHALL live in diaosi_types_pkg; ramstate_t and word_t come from cpu_types_pkg.
REQ-037 Counters SHALL be one sub-module, mem_arb_perf, instantiated only under MEM_ARB_PERF_EN.

Verification
REQ-038 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C010004 -> ihit pulse on cycle 3, iload=0x8C010004, ramREN=1 throughout.
REQ-039 iREN=dREN=1 in IDLE, daddr=0x100 -> DACC first, ramaddr=0x100; after dhit, IFETCH with ramaddr=iaddr.
REQ-040 dREN=dWEN=1, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit on ACCESS.
REQ-041 TIMEOUT=4, ramstate held BUSY -> FAULT after 4 granted cycles, mem_err=1, strobes 0 until nRST.
REQ-042 nRST low during BUSY DACC -> outputs 0 immediately, IDLE after release, no dhit.
REQ-043 MEM_ARB_PERF_EN set, 3 fetches each 1 BUSY cycle -> icount=3, scount=3, dcount=0.
